// File: rtl/img_pkg.sv
// Shared constants for the pixel-processing datapath: operation codes,
// sequencer state encoding, default frame geometry and counter widths.
package img_pkg;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;

  // Row/col widths cover WIDTH <= 2047 and HEIGHT <= 1023.
  localparam int ROW_W   = 10;
  localparam int COL_W   = 11;
  localparam int BLANK_W = 16;

  typedef enum logic [1:0] {
    OP_PASS   = 2'd0,
    OP_BRIGHT = 2'd1,
    OP_INVERT = 2'd2,
    OP_THRESH = 2'd3
  } op_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LINE   = 2'd1;
  localparam logic [1:0] ST_HBLANK = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/pix_scan_counter.sv
// Row/column scan position and memory line base for one frame.
// The line base starts at the last memory line for bottom-up (BMP) order
// and steps by one line per completed row; the address is base + col.
module pix_scan_counter
  import img_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_load,
  input  logic              i_issue,
  output logic [ROW_W-1:0]  o_row,
  output logic [COL_W-1:0]  o_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_line_end,
  output logic              o_frame_end
);

  localparam logic [ADDR_W-1:0] BASE_INIT = (BOTTOM_UP != 0) ? ADDR_W'((HEIGHT-1)*WIDTH) : '0;
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH-1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT-1);

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_base;

  // Advance col per issue; at end of line wrap col and step row/base.
  // The final pixel leaves the position parked until the next load.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_row  <= '0;
      r_col  <= '0;
      r_base <= '0;
    end else if (i_load) begin
      r_row  <= '0;
      r_col  <= '0;
      r_base <= BASE_INIT;
    end else if (i_issue) begin
      if (r_col == COL_LAST) begin
        if (r_row != ROW_LAST) begin
          r_row  <= r_row + 1'b1;
          r_col  <= '0;
          r_base <= (BOTTOM_UP != 0) ? (r_base - LINE_STEP) : (r_base + LINE_STEP);
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_addr      = r_base + ADDR_W'(r_col);
  assign o_line_end  = (r_col == COL_LAST);
  assign o_frame_end = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/frame_read_ctrl.sv
// Frame read sequencer: scans one frame out of pixel memory, one read per
// accepted pixel, with horizontal blanking and valid/ready backpressure.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_LINE   | issuing reads for the current line
// ST_HBLANK | idle gap between lines, no reads issued
// ST_DRAIN  | last read issued, waiting for final pixel acceptance
module frame_read_ctrl
  import img_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int HBLANK    = 16,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        cfg_op_i,
  input  logic [7:0]        cfg_value_i,
  input  logic              cfg_sign_i,
  input  logic [7:0]        cfg_thresh_i,
  output logic [1:0]        op_o,
  output logic [7:0]        value_o,
  output logic              sign_o,
  output logic [7:0]        thresh_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [9:0]        row_o,
  output logic [10:0]       col_o,
  output logic              line_last_o,
  output logic              frame_last_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(HBLANK);

  if (WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_addr_chk
    $error("frame_read_ctrl: WIDTH*HEIGHT exceeds pixel address space");
  end

  logic [1:0]         r_state;
  logic [BLANK_W-1:0] r_blank;
  logic               r_valid;
  logic               r_done;
  logic [1:0]         r_op;
  logic [7:0]         r_value;
  logic               r_sign;
  logic [7:0]         r_thresh;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic               r_line_last;
  logic               r_frame_last;

  logic               w_start;
  logic               w_abort;
  logic               w_issue;
  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_col;
  logic               w_line_end;
  logic               w_frame_end;

  assign w_start = (r_state == ST_IDLE) && start_i && !abort_i;
  assign w_abort = (r_state != ST_IDLE) && abort_i;
  assign w_issue = (r_state == ST_LINE) && (!r_valid || pix_ready_i);

  pix_scan_counter #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .BOTTOM_UP (BOTTOM_UP),
    .ADDR_W    (ADDR_W)
  ) u_scan (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .i_load      (w_start),
    .i_issue     (w_issue),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_addr      (mem_addr_o),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  // Sequencer: line issue, blanking countdown, drain and done pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_blank <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) r_state <= ST_LINE;
          end
          ST_LINE: begin
            if (w_issue && w_line_end) begin
              if (w_frame_end) begin
                r_state <= ST_DRAIN;
              end else if (HBLANK != 0) begin
                r_state <= ST_HBLANK;
                r_blank <= BLANK_INIT;
              end
            end
          end
          ST_HBLANK: begin
            r_blank <= r_blank - 1'b1;
            if (r_blank <= 1) r_state <= ST_LINE;
          end
          ST_DRAIN: begin
            if (!r_valid || (pix_ready_i && r_frame_last)) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Memory dout is valid one cycle after a read and holds until accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)          r_valid <= 1'b0;
    else if (w_abort)      r_valid <= 1'b0;
    else if (w_issue)      r_valid <= 1'b1;
    else if (pix_ready_i)  r_valid <= 1'b0;
  end

  // Position tags follow the read so they line up with pix_valid_o.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_row        <= '0;
      r_col        <= '0;
      r_line_last  <= 1'b0;
      r_frame_last <= 1'b0;
    end else if (w_issue) begin
      r_row        <= w_row;
      r_col        <= w_col;
      r_line_last  <= w_line_end;
      r_frame_last <= w_frame_end;
    end
  end

  // Configuration captured only on an accepted start, stable for the frame.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_op     <= '0;
      r_value  <= '0;
      r_sign   <= 1'b0;
      r_thresh <= '0;
    end else if (w_start) begin
      r_op     <= cfg_op_i;
      r_value  <= cfg_value_i;
      r_sign   <= cfg_sign_i;
      r_thresh <= cfg_thresh_i;
    end
  end

  assign op_o         = r_op;
  assign value_o      = r_value;
  assign sign_o       = r_sign;
  assign thresh_o     = r_thresh;
  assign mem_rd_en_o  = w_issue;
  assign pix_valid_o  = r_valid;
  assign row_o        = r_row;
  assign col_o        = r_col;
  assign line_last_o  = r_line_last;
  assign frame_last_o = r_frame_last;
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_done_o = r_done;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Bench for frame_read_ctrl: cycle table for a full-rate frame, scoreboard
// of addresses and pixel tags, plus stall, config, abort and reset sequences.
module tb_frame_read_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
  localparam int H2 = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          start_i = 0, abort_i = 0, pix_ready_i = 1;
  logic [1:0]    cfg_op_i = 0;
  logic [7:0]    cfg_value_i = 0, cfg_thresh_i = 0;
  logic          cfg_sign_i = 0;
  logic [1:0]    op_o;
  logic [7:0]    value_o, thresh_o;
  logic          sign_o, mem_rd_en_o, pix_valid_o, line_last_o, frame_last_o, busy_o, frame_done_o;
  logic [AW-1:0] mem_addr_o;
  logic [9:0]    row_o;
  logic [10:0]   col_o;

  frame_read_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .BOTTOM_UP(1), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start_i), .abort_i(abort_i),
    .cfg_op_i(cfg_op_i), .cfg_value_i(cfg_value_i), .cfg_sign_i(cfg_sign_i), .cfg_thresh_i(cfg_thresh_i),
    .op_o(op_o), .value_o(value_o), .sign_o(sign_o), .thresh_o(thresh_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .row_o(row_o), .col_o(col_o), .line_last_o(line_last_o), .frame_last_o(frame_last_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o));

  logic        s2_start = 0;
  logic [1:0]  s2_op;
  logic [7:0]  s2_value, s2_thresh;
  logic        s2_sign, s2_rd, s2_valid, s2_ll, s2_fl, s2_busy, s2_done;
  logic [2:0]  s2_addr;
  logic [9:0]  s2_row;
  logic [10:0] s2_col;

  frame_read_ctrl #(.WIDTH(W), .HEIGHT(H2), .HBLANK(0), .BOTTOM_UP(0), .ADDR_W(3)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(s2_start), .abort_i(1'b0),
    .cfg_op_i(2'd0), .cfg_value_i(8'd0), .cfg_sign_i(1'b0), .cfg_thresh_i(8'd0),
    .op_o(s2_op), .value_o(s2_value), .sign_o(s2_sign), .thresh_o(s2_thresh),
    .mem_rd_en_o(s2_rd), .mem_addr_o(s2_addr), .pix_valid_o(s2_valid), .pix_ready_i(1'b1),
    .row_o(s2_row), .col_o(s2_col), .line_last_o(s2_ll), .frame_last_o(s2_fl),
    .busy_o(s2_busy), .frame_done_o(s2_done));

  typedef struct {
    logic rdy;
    logic exp_rd;
    int   exp_addr;   // -1: address not compared this cycle
    logic exp_valid;
    logic exp_done;
  } vec_t;

  typedef struct {
    int row;
    int col;
    int ll;
    int fl;
  } pix_t;

  vec_t vecs[$];
  int   exp_addr_q[$];
  pix_t exp_pix_q[$];
  int   n_vec = 0, n_err = 0;
  int   acc_cnt = 0, done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic rd, input int addr, input logic v, input logic d);
    vecs.push_back('{1'b1, rd, addr, v, d});
  endtask

  // Expected scan order straight from the frame geometry (bottom-up lines).
  task automatic load_model();
    exp_addr_q.delete();
    exp_pix_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        exp_addr_q.push_back((H - 1 - r) * W + c);
        exp_pix_q.push_back('{r, c, (c == W-1) ? 1 : 0, ((r == H-1) && (c == W-1)) ? 1 : 0});
      end
  endtask

  task automatic pulse_start(input logic [1:0] op, input logic [7:0] val, input logic sgn, input logic [7:0] thr);
    @(posedge HCLK); #1;
    cfg_op_i = op; cfg_value_i = val; cfg_sign_i = sgn; cfg_thresh_i = thr;
    start_i = 1;
    @(posedge HCLK); #1;
    start_i = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, int'(mem_rd_en_o), 0);
    check({tag, "_addr"}, int'(mem_addr_o), 0);
    check({tag, "_valid"}, int'(pix_valid_o), 0);
    check({tag, "_rowcol"}, int'(row_o) + int'(col_o), 0);
    check({tag, "_lasts"}, int'(line_last_o) + int'(frame_last_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(frame_done_o), 0);
    check({tag, "_cfg"}, int'(op_o) + int'(value_o) + int'(sign_o) + int'(thresh_o), 0);
  endtask

  // Scoreboard: pop expected address on each read, expected tags on each accept.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (mem_rd_en_o) begin
        if (exp_addr_q.size() == 0) check("spurious_read", int'(mem_addr_o), -1);
        else check("read_addr", int'(mem_addr_o), exp_addr_q.pop_front());
      end
      if (pix_valid_o && pix_ready_i) begin
        acc_cnt++;
        if (exp_pix_q.size() == 0) check("spurious_accept", int'(col_o), -1);
        else begin
          pix_t p;
          p = exp_pix_q.pop_front();
          check("acc_row", int'(row_o), p.row);
          check("acc_col", int'(col_o), p.col);
          check("acc_line_last", int'(line_last_o), p.ll);
          check("acc_frame_last", int'(frame_last_o), p.fl);
        end
      end
      if (frame_done_o) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit found;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1;
    @(negedge HCLK);
    check_all_zero("reset");

    // Full-throughput frame, cycle by cycle
    add_vec(1, 8, 0, 0);  add_vec(1, 9, 1, 0);  add_vec(1, 10, 1, 0); add_vec(1, 11, 1, 0);
    add_vec(0, -1, 1, 0); add_vec(0, -1, 0, 0);
    add_vec(1, 4, 0, 0);  add_vec(1, 5, 1, 0);  add_vec(1, 6, 1, 0);  add_vec(1, 7, 1, 0);
    add_vec(0, -1, 1, 0); add_vec(0, -1, 0, 0);
    add_vec(1, 0, 0, 0);  add_vec(1, 1, 1, 0);  add_vec(1, 2, 1, 0);  add_vec(1, 3, 1, 0);
    add_vec(0, -1, 1, 0); add_vec(0, -1, 0, 1); add_vec(0, -1, 0, 0);
    load_model();
    acc_cnt = 0;
    pulse_start(2'd0, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      pix_ready_i = vecs[i].rdy;
      @(negedge HCLK);
      check($sformatf("tbl%0d_rd_en", i), int'(mem_rd_en_o), int'(vecs[i].exp_rd));
      if (vecs[i].exp_addr >= 0) check($sformatf("tbl%0d_addr", i), int'(mem_addr_o), vecs[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), int'(pix_valid_o), int'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_done", i), int'(frame_done_o), int'(vecs[i].exp_done));
      @(posedge HCLK); #1;
    end
    check("full_accepts", acc_cnt, 12);
    check("full_left", exp_addr_q.size() + exp_pix_q.size(), 0);

    // Backpressure: ready low for three cycles while pixel (0,2) is pending
    load_model();
    acc_cnt = 0; d0 = done_cnt;
    pulse_start(2'd0, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 30; i++) begin
      pix_ready_i = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      @(negedge HCLK);
      if (i >= 3 && i <= 5) begin
        check("stall_rd_en", int'(mem_rd_en_o), 0);
        check("stall_valid", int'(pix_valid_o), 1);
        check("stall_row", int'(row_o), 0);
        check("stall_col", int'(col_o), 2);
      end
      @(posedge HCLK); #1;
    end
    pix_ready_i = 1;
    check("bp_accepts", acc_cnt, 12);
    check("bp_done", done_cnt - d0, 1);
    check("bp_left", exp_addr_q.size() + exp_pix_q.size(), 0);

    // HBLANK=0, top-down: addresses 0..7 on back-to-back cycles
    @(posedge HCLK); #1 s2_start = 1;
    @(posedge HCLK); #1 s2_start = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      check($sformatf("nb%0d_rd_en", i), int'(s2_rd), 1);
      check($sformatf("nb%0d_addr", i), int'(s2_addr), i);
    end
    @(negedge HCLK);
    check("nb_after_rd_en", int'(s2_rd), 0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge HCLK);
      if (s2_done) found = 1;
    end
    check("nb_done", int'(found), 1);

    // Config latch and start while busy
    load_model();
    acc_cnt = 0; d0 = done_cnt;
    pulse_start(2'd3, 8'h11, 1'b1, 8'd90);
    for (int i = 0; i < 30; i++) begin
      if (i == 5) begin cfg_op_i = 2'd1; cfg_value_i = 8'd100; cfg_sign_i = 0; cfg_thresh_i = 8'd7; start_i = 1; end
      if (i == 6) start_i = 0;
      @(negedge HCLK);
      if (i == 10) begin
        check("cfg_op_mid", int'(op_o), 3);
        check("cfg_thresh_mid", int'(thresh_o), 90);
        check("cfg_value_mid", int'(value_o), 17);
        check("cfg_sign_mid", int'(sign_o), 1);
      end
      @(posedge HCLK); #1;
    end
    check("cfg_accepts", acc_cnt, 12);
    check("cfg_done", done_cnt - d0, 1);
    check("cfg_op_after", int'(op_o), 3);
    check("cfg_busy_after", int'(busy_o), 0);

    // Abort at row 1 col 2
    load_model();
    d0 = done_cnt;
    pulse_start(2'd1, 8'd100, 1'b0, 8'd0);
    @(negedge HCLK);
    check("relatch_op", int'(op_o), 1);
    check("relatch_value", int'(value_o), 100);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pix_valid_o && row_o == 10'd1 && col_o == 11'd2) found = 1;
      else @(negedge HCLK);
    end
    check("abort_point_reached", int'(found), 1);
    abort_i = 1;
    @(posedge HCLK); #1 abort_i = 0;
    @(negedge HCLK);
    check("abort_busy", int'(busy_o), 0);
    check("abort_valid", int'(pix_valid_o), 0);
    repeat (5) @(negedge HCLK);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_rd", int'(mem_rd_en_o), 0);

    load_model();
    acc_cnt = 0; d0 = done_cnt;
    pulse_start(2'd1, 8'd100, 1'b0, 8'd0);
    repeat (25) @(negedge HCLK);
    check("rescan_accepts", acc_cnt, 12);
    check("rescan_done", done_cnt - d0, 1);
    check("rescan_left", exp_addr_q.size() + exp_pix_q.size(), 0);

    // Asynchronous reset mid-line
    load_model();
    pulse_start(2'd2, 8'd5, 1'b1, 8'd9);
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 0;
    #1 check_all_zero("async_rst");
    exp_addr_q.delete();
    exp_pix_q.delete();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1;
    d0 = done_cnt;
    repeat (6) @(negedge HCLK);
    check("post_rst_busy", int'(busy_o), 0);
    check("post_rst_rd_en", int'(mem_rd_en_o), 0);
    check("post_rst_done", done_cnt - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
